// File: rtl/fsched_pkg.sv
// Shared types for the FFT frame scheduler: FSM states, channel count and
// channel index type, plus a small helper that names the "other" channel.
package fsched_pkg;

  localparam int unsigned NUM_CH = 2;

  typedef logic ch_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FEED     = 2'd1,
    WAIT_OUT = 2'd2
  } state_t;

  // With two channels the alternate channel is simply the inverted index.
  function automatic ch_idx_t other_ch(input ch_idx_t c);
    return ~c;
  endfunction

endpackage

// File: rtl/fft_frame_sched_if.sv
// Bundle of everything the scheduler exchanges with the ADC FIFOs, the FFT
// core and the host. master = scheduler side, slave = environment side.
interface fft_frame_sched_if #(
  parameter int DATA_W = 8
);
  logic              sched_en;
  logic [1:0]        ch_en;
  logic [1:0]        ch_end;
  logic [1:0]        ch_empty;
  logic [DATA_W-1:0] ch0_data;
  logic [DATA_W-1:0] ch1_data;
  logic [1:0]        ch_rdreq;
  logic              sink_valid;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic              sink_ready;
  logic              source_valid;
  logic              source_sop;
  logic              source_eop;
  logic              source_ready;
  logic              frame_ch;
  logic              busy;
  logic              frame_done;
  logic              timeout_err;

  modport master (
    input  sched_en, ch_en, ch_end, ch_empty, ch0_data, ch1_data,
    input  sink_ready, source_valid, source_sop, source_eop,
    output ch_rdreq, sink_valid, sink_sop, sink_eop, sink_real,
    output source_ready, frame_ch, busy, frame_done, timeout_err
  );

  modport slave (
    output sched_en, ch_en, ch_end, ch_empty, ch0_data, ch1_data,
    output sink_ready, source_valid, source_sop, source_eop,
    input  ch_rdreq, sink_valid, sink_sop, sink_eop, sink_real,
    input  source_ready, frame_ch, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/fsched_rr_arb.sv
// Two-way round-robin arbiter. The priority pointer names the channel that
// was not served last; it moves only when the scheduler accepts a grant.
module fsched_rr_arb
  import fsched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_adv,
  output ch_idx_t           o_gnt,
  output logic              o_gnt_vld
);

  ch_idx_t r_prio;

  // Grant the priority channel if it requests, otherwise the other one.
  always_comb begin
    o_gnt     = r_prio;
    o_gnt_vld = 1'b0;
    if (i_req[r_prio]) begin
      o_gnt     = r_prio;
      o_gnt_vld = 1'b1;
    end else if (i_req[other_ch(r_prio)]) begin
      o_gnt     = other_ch(r_prio);
      o_gnt_vld = 1'b1;
    end else begin
      o_gnt     = r_prio;
      o_gnt_vld = 1'b0;
    end
  end

  // After a grant is taken, the channel just served loses priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_adv) begin
      r_prio <= other_ch(o_gnt);
    end else begin
      r_prio <= r_prio;
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// FFT frame scheduler: picks an ADC channel round-robin, streams exactly
// FRAME_LEN samples from its show-ahead FIFO into the FFT sink, then waits
// for the FFT source end-of-packet before the next frame.
// Optional WAIT_OUT watchdog: define FSCHED_TIMEOUT_EN to enable it.
module fft_frame_sched
  import fsched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 1024,
  parameter int TIMEOUT   = 8192
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_frame_sched_if.master  bus
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  ch_idx_t           r_frame_ch;
  logic              r_frame_done;
  logic              r_timeout_err;

  logic [NUM_CH-1:0] w_req;
  ch_idx_t           w_gnt;
  logic              w_gnt_vld;
  logic              w_adv;
  logic              w_feed;
  logic              w_valid;
  logic              w_beat;
  logic              w_last;
  logic              w_src_eop;
  logic              w_done_set;
  logic              w_to_set;
  logic              w_to_hit;
  logic [DATA_W-1:0] w_head;
  logic              w_unused_sop;

  // source_sop carries no meaning for the scheduler; only eop ends a frame.
  assign w_unused_sop = bus.source_sop;

  assign w_req     = bus.ch_en & bus.ch_end & ~bus.ch_empty;
  assign w_feed    = (r_state == FEED);
  assign w_head    = r_frame_ch ? bus.ch1_data : bus.ch0_data;
  assign w_valid   = w_feed & ~bus.ch_empty[r_frame_ch];
  assign w_beat    = w_valid & bus.sink_ready;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_src_eop = (r_state == WAIT_OUT) & bus.source_valid & bus.source_eop;

  fsched_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_req),
    .i_adv    (w_adv),
    .o_gnt    (w_gnt),
    .o_gnt_vld(w_gnt_vld)
  );

`ifdef FSCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_wcnt;

  assign w_to_hit = (r_state == WAIT_OUT) & ~w_src_eop &
                    (r_wcnt == TO_W'(TIMEOUT - 1));

  // Count consecutive WAIT_OUT cycles; cleared whenever we are elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= {TO_W{1'b0}};
    end else if ((r_state == WAIT_OUT) && !w_to_hit && !w_src_eop) begin
      r_wcnt <= r_wcnt + 1'b1;
    end else begin
      r_wcnt <= {TO_W{1'b0}};
    end
  end
`else
  logic w_unused_timeout;
  assign w_to_hit         = 1'b0;
  assign w_unused_timeout = (TIMEOUT == 32'sd0);
`endif

  // Next-state logic and the one-shot strobes that accompany transitions.
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_done_set  = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sched_en && w_gnt_vld) begin
          w_state_nxt = FEED;
          w_adv       = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FEED: begin
        if (w_beat && w_last) begin
          w_state_nxt = WAIT_OUT;
        end else begin
          w_state_nxt = FEED;
        end
      end
      WAIT_OUT: begin
        if (w_src_eop) begin
          w_state_nxt = IDLE;
          w_done_set  = 1'b1;
        end else if (w_to_hit) begin
          w_state_nxt = IDLE;
          w_to_set    = 1'b1;
        end else begin
          w_state_nxt = WAIT_OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat counter: advances only on accepted beats, so stalls keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_beat) begin
      r_cnt <= w_last ? {CNT_W{1'b0}} : (r_cnt + 1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Frame owner is captured when the grant is taken and held for the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_ch <= 1'b0;
    end else if (w_adv) begin
      r_frame_ch <= w_gnt;
    end else begin
      r_frame_ch <= r_frame_ch;
    end
  end

  // Completion and watchdog pulses, one cycle each in the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_done  <= w_done_set;
      r_timeout_err <= w_to_set;
    end
  end

  assign bus.sink_valid   = w_valid;
  assign bus.sink_sop     = w_valid & (r_cnt == {CNT_W{1'b0}});
  assign bus.sink_eop     = w_valid & w_last;
  assign bus.sink_real    = w_feed ? w_head : {DATA_W{1'b0}};
  assign bus.ch_rdreq     = {w_beat & r_frame_ch, w_beat & ~r_frame_ch};
  assign bus.source_ready = (r_state != IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.frame_ch     = r_frame_ch;
  assign bus.frame_done   = r_frame_done;
  assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: a frame-level model (mode / beat count / rr
// pointer, plus FIFO queues carrying sequence-coded words) predicts every
// output each cycle; directed phases pin frame shape, underrun, ready
// toggling, mid-frame reset and grant order, then a random phase follows.
module tb_fft_frame_sched;
  localparam int DW = 8;
  localparam int FL = 1024;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_frame_sched_if #(.DATA_W(DW)) bus ();

  fft_frame_sched #(.DATA_W(DW), .FRAME_LEN(FL), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model: 0 idle, 1 feeding, 2 waiting for FFT output
  int m_mode = 0, m_cnt = 0, m_prio = 0, m_fch = 0, m_wcyc = 0, m_frames = 0;
  bit m_done_p = 1'b0, m_to_p = 1'b0;
  bit p_valid, p_beat;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int wseq[2] = '{0, 0};
  int rseq[2] = '{0, 0};

  // knobs
  bit       k_rand = 1'b0;
  bit [1:0] k_en = 2'b00;
  int       k_ready_mode = 0, k_push = 100, k_eop = 10, k_frame_limit = 0;
  bit       k_und300 = 1'b0, k_rst500 = 1'b0;
  int       und_left = 0, rst_hold = 0;
  bit       und_active = 1'b0;

  // observations of the DUT
  int dut_beats = 0, dut_pops = 0, dut_done = 0, dut_to = 0, und_stall = 0;
  int cyc = 0, eop_cyc = 0, to_dist = 0;
  bit prev_busy = 1'b0;
  int grants[$];
  int exp_g[4] = '{0, 1, 0, 1};

  function automatic logic [DW-1:0] gen_word(input int c, input int s);
    int t;
    t = s * 37 + c * 101 + 5;
    return t[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sink_valid"}, bus.sink_valid, 0);
    chk({tag, "_sink_sop"}, bus.sink_sop, 0);
    chk({tag, "_sink_eop"}, bus.sink_eop, 0);
    chk({tag, "_sink_real"}, bus.sink_real, 0);
    chk({tag, "_ch_rdreq"}, bus.ch_rdreq, 0);
    chk({tag, "_source_ready"}, bus.source_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_frame_ch"}, bus.frame_ch, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_prio = 0; m_fch = 0; m_wcyc = 0;
    m_done_p = 1'b0; m_to_p = 1'b0;
    dut_beats = 0; und_left = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    rst_hold = 2;
  endtask

  // predict outputs from model state and the inputs currently applied
  task automatic compare_cycle();
    logic [DW-1:0] exp_real;
    logic [1:0]    exp_rd;
    p_valid  = (m_mode == 1) && !bus.ch_empty[m_fch];
    p_beat   = p_valid && bus.sink_ready;
    exp_real = (m_mode == 1) ? ((m_fch == 1) ? bus.ch1_data : bus.ch0_data) : '0;
    exp_rd   = p_beat ? ((m_fch == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("sink_valid", bus.sink_valid, p_valid);
    chk("sink_sop", bus.sink_sop, p_valid && (m_cnt == 0));
    chk("sink_eop", bus.sink_eop, p_valid && (m_cnt == FL - 1));
    chk("sink_real", bus.sink_real, exp_real);
    chk("ch_rdreq", bus.ch_rdreq, exp_rd);
    chk("source_ready", bus.source_ready, m_mode != 0);
    chk("busy", bus.busy, m_mode != 0);
    chk("frame_ch", bus.frame_ch, m_fch);
    chk("frame_done", bus.frame_done, m_done_p);
    chk("timeout_err", bus.timeout_err, m_to_p);
    if (p_beat) chk("sample_seq", bus.sink_real, gen_word(m_fch, rseq[m_fch]));
    if (bus.sink_valid && bus.sink_ready) begin
      if (bus.sink_sop) chk("sop_beat_idx", dut_beats, 0);
      if (bus.sink_eop) begin
        chk("eop_beat_idx", dut_beats, FL - 1);
        dut_beats = 0;
        eop_cyc = cyc;
      end else begin
        dut_beats++;
      end
    end
    if (bus.ch_rdreq != 2'b00) dut_pops++;
    if (und_active) begin
      chk("underrun_valid", bus.sink_valid, 0);
      if (!bus.sink_valid && bus.ch_rdreq == 2'b00) und_stall++;
    end
    if (bus.frame_done) dut_done++;
    if (bus.timeout_err) begin
      dut_to++;
      to_dist = cyc - eop_cyc;
    end
    if (bus.busy && !prev_busy) grants.push_back(int'(bus.frame_ch));
    prev_busy = bus.busy;
  endtask

  task automatic update_model();
    bit [1:0] elig;
    m_done_p = 1'b0;
    m_to_p   = 1'b0;
    case (m_mode)
      0: begin
        elig = bus.ch_en & bus.ch_end & ~bus.ch_empty;
        if (bus.sched_en && elig != 2'b00) begin
          m_fch  = elig[m_prio] ? m_prio : 1 - m_prio;
          m_prio = 1 - m_fch;
          m_mode = 1;
          m_cnt  = 0;
        end
      end
      1: begin
        if (p_beat) begin
          if (m_fch == 1) void'(q1.pop_front()); else void'(q0.pop_front());
          rseq[m_fch]++;
          m_cnt++;
          if (m_cnt == FL) begin
            m_cnt  = 0;
            m_mode = 2;
            m_wcyc = 0;
          end
        end
      end
      default: begin
        if (bus.source_valid && bus.source_eop) begin
          m_mode = 0; m_done_p = 1'b1; m_frames++;
        end
`ifdef FSCHED_TIMEOUT_EN
        else begin
          m_wcyc++;
          if (m_wcyc == TO) begin
            m_mode = 0; m_to_p = 1'b1; m_frames++;
          end
        end
`endif
      end
    endcase
  endtask

  task automatic apply_inputs();
    bit [1:0] fe;
    fe = 2'b00;
    und_active = 1'b0;
    if (k_rand) begin
      bus.ch_en  = 2'($urandom_range(0, 3));
      bus.ch_end = 2'($urandom_range(0, 3));
    end else begin
      bus.ch_en  = k_en;
      bus.ch_end = k_en;
    end
    bus.sched_en = (m_frames < k_frame_limit) && (!k_rand || $urandom_range(0, 7) != 0);
    case (k_ready_mode)
      0:       bus.sink_ready = 1'b1;
      1:       bus.sink_ready = ~bus.sink_ready;
      default: bus.sink_ready = 1'($urandom_range(0, 1));
    endcase
    if (q0.size() < 6 && $urandom_range(0, 99) < k_push) begin
      q0.push_back(gen_word(0, wseq[0])); wseq[0]++;
    end
    if (q1.size() < 6 && $urandom_range(0, 99) < k_push) begin
      q1.push_back(gen_word(1, wseq[1])); wseq[1]++;
    end
    if (k_und300 && m_mode == 1 && m_cnt == 300) begin
      und_left = 5;
      k_und300 = 1'b0;
    end
    if (und_left > 0) begin
      fe[m_fch]  = 1'b1;
      und_active = 1'b1;
      und_left--;
    end
    bus.ch_empty[0] = fe[0] || (q0.size() == 0);
    bus.ch_empty[1] = fe[1] || (q1.size() == 0);
    bus.ch0_data = (q0.size() != 0) ? q0[0] : DW'($urandom_range(0, 255));
    bus.ch1_data = (q1.size() != 0) ? q1[0] : DW'($urandom_range(0, 255));
    bus.source_valid = 1'($urandom_range(0, 1));
    bus.source_eop   = ($urandom_range(0, 99) < k_eop);
    bus.source_sop   = 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    if (rst_n) update_model();
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst_n = 1'b1;
    end
    if (k_rst500 && rst_n && m_mode == 1 && m_cnt == 500) begin
      k_rst500 = 1'b0;
      do_reset("midreset");
    end
    apply_inputs();
    cyc++;
  endtask

  task automatic run_frames(input int n, input int bound);
    int tgt;
    int c;
    tgt = m_frames + n;
    k_frame_limit = tgt;
    c = 0;
    while (m_frames < tgt && c < bound) begin
      step();
      c++;
    end
    if (m_frames < tgt) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_wait: reached %0d frames, want %0d", m_frames, tgt);
    end
    repeat (3) step();
  endtask

  task automatic clear_obs();
    dut_pops = 0; dut_done = 0; dut_to = 0; und_stall = 0;
  endtask

  initial begin
    bus.sink_ready = 1'b0;
    apply_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    rst_hold = 3;
    repeat (4) step();

    // single channel, full FIFO, sink always ready
    k_en = 2'b01; k_ready_mode = 0; k_push = 100; k_eop = 10;
    clear_obs();
    run_frames(1, 6000);
    chk("a_pops", dut_pops, FL);
    chk("a_end_pulses", dut_done + dut_to, 1);

    // FIFO underrun of 5 cycles at beat 300
    clear_obs();
    k_und300 = 1'b1;
    run_frames(1, 6000);
    chk("c_pops", dut_pops, FL);
    chk("c_underrun_stall", und_stall, 5);

    // sink_ready toggling every cycle
    clear_obs();
    k_ready_mode = 1;
    run_frames(1, 8000);
    chk("d_pops", dut_pops, FL);

    // reset in the middle of a frame at beat 500
    clear_obs();
    k_ready_mode = 0;
    k_rst500 = 1'b1;
    run_frames(1, 8000);
    chk("r_pops", dut_pops, 500 + FL);
    chk("r_end_pulses", dut_done + dut_to, 1);

    // back to reset priority, then both channels eligible for 4 frames
    do_reset("idlereset");
    repeat (4) step();
    k_en = 2'b11;
    grants.delete();
    clear_obs();
    run_frames(4, 12000);
    chk("b_grant_cnt", grants.size(), 4);
    if (grants.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("b_grant_seq", grants[i], exp_g[i]);
    end

`ifdef FSCHED_TIMEOUT_EN
    // no source_eop at all: watchdog must end the wait
    k_en = 2'b01; k_eop = 0;
    clear_obs();
    run_frames(1, 6000);
    chk("t_timeout_pulses", dut_to, 1);
    chk("t_timeout_dist", to_dist, TO + 1);
    k_eop = 10;
`endif

    // fully random traffic
    k_rand = 1'b1; k_ready_mode = 2; k_push = 60; k_eop = 10;
    run_frames(3, 40000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
